// File: rtl/rvh_noc_pkg.sv
// rtl/rvh_noc_pkg.sv - NoC shared types, sizes and the XY first-hop routing helper
package rvh_noc_pkg;

  localparam int NodeID_X_Width          = 2;
  localparam int NodeID_Y_Width          = 2;
  localparam int VC_ID_NUM_MAX_W         = 2;
  localparam int VC_DEPTH_MAX            = 2;
  localparam int LOCAL_INJECT_FIFO_DEPTH = 4;
  localparam int FLIT_DATA_W             = 32;

  // Port enum values double as the local-input VC id for N/S/E/W
  typedef enum logic [2:0] {
    N  = 3'd0,
    S  = 3'd1,
    E  = 3'd2,
    W  = 3'd3,
    L0 = 3'd4
  } io_port_t;

  typedef struct packed {
    logic [NodeID_X_Width-1:0] x_position;
    logic [NodeID_Y_Width-1:0] y_position;
  } node_id_t;

  typedef logic [FLIT_DATA_W-1:0] cache_scu_cc_test_t;

  typedef struct packed {
    logic [3:0]         qos_value;
    node_id_t           src_id;
    node_id_t           tgt_id;
    cache_scu_cc_test_t data;
  } flit_payload_t;

  typedef struct packed {
    logic     is_self;
    io_port_t port;
  } first_hop_t;

  // X-first dimension-order route; is_self marks a target equal to the current node
  function automatic first_hop_t xy_first_hop(input node_id_t cur, input node_id_t tgt);
    first_hop_t hop;
    hop.is_self = 1'b0;
    hop.port    = N;
    if (tgt.x_position > cur.x_position)      hop.port = E;
    else if (tgt.x_position < cur.x_position) hop.port = W;
    else if (tgt.y_position > cur.y_position) hop.port = N;
    else if (tgt.y_position < cur.y_position) hop.port = S;
    else                                      hop.is_self = 1'b1;
    return hop;
  endfunction

endpackage

// File: rtl/rvh_noc_inject_fifo.sv
// rtl/rvh_noc_inject_fifo.sv - small power-of-two payload FIFO with registered occupancy
module rvh_noc_inject_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);
  localparam logic [PW-1:0] LP_PONE  = PW'(1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_count == LP_DEPTH);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Storage array carries no reset; only pointers and occupancy define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PONE;
      if (w_push && !w_pop)      r_count <= r_count + LP_ONE;
      else if (w_pop && !w_push) r_count <= r_count - LP_ONE;
    end
  end

endmodule

// File: rtl/rvh_noc_local_inject.sv
// rtl/rvh_noc_local_inject.sv - device-to-router L0 injector with XY first hop and per-VC credits
module rvh_noc_local_inject
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM     = 4,
  parameter int VC_DEPTH   = VC_DEPTH_MAX,
  parameter int FIFO_DEPTH = LOCAL_INJECT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  node_id_t                   node_id_i,
  input  logic                       pld_vld_i,
  input  flit_payload_t              pld_i,
  output logic                       pld_rdy_o,
  output logic                       tx_flit_vld_o,
  output flit_payload_t              tx_flit_o,
  output logic [VC_ID_NUM_MAX_W-1:0] tx_vc_id_o,
  output io_port_t                   tx_look_ahead_routing_o,
  input  logic                       rx_lcrd_vld_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] rx_lcrd_id_i,
  output logic                       drop_err_o
);

  localparam int CW = $clog2(VC_DEPTH + 1);
  localparam logic [CW-1:0] LP_FULL = CW'(VC_DEPTH);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic                       w_push;
  logic                       w_pop;
  flit_payload_t              w_head;
  first_hop_t                 w_hop;
  logic [VC_ID_NUM_MAX_W-1:0] w_head_vc;
  logic                       w_send;
  logic                       w_drop;
  logic                       w_lcrd_legal;
  logic [CW-1:0]              w_credit [VC_NUM];

  logic                       r_tx_vld;
  flit_payload_t              r_tx_flit;
  logic [VC_ID_NUM_MAX_W-1:0] r_tx_vc;
  io_port_t                   r_tx_route;
  logic                       r_drop;

  assign pld_rdy_o = !w_fifo_full;
  assign w_push    = pld_vld_i && !w_fifo_full;

  rvh_noc_inject_fifo #(
    .T     (flit_payload_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (pld_i),
    .pop_i       (w_pop),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .head_o      (w_head)
  );

  // Head routing: a self-targeted head is discarded, otherwise it waits for a credit on its VC
  assign w_hop     = xy_first_hop(node_id_i, w_head.tgt_id);
  assign w_head_vc = VC_ID_NUM_MAX_W'(w_hop.port);
  assign w_drop    = !w_fifo_empty && w_hop.is_self;
  assign w_send    = !w_fifo_empty && !w_hop.is_self && (w_credit[w_head_vc] != '0);
  assign w_pop     = w_send || w_drop;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_credit
    logic          w_inc;
    logic          w_dec;
    logic [CW-1:0] r_cnt;
    assign w_inc       = rx_lcrd_vld_i && (rx_lcrd_id_i == VC_ID_NUM_MAX_W'(g));
    assign w_dec       = w_send && (w_head_vc == VC_ID_NUM_MAX_W'(g));
    assign w_credit[g] = r_cnt;
    // Credit counter: simultaneous return and consume cancel; an overflowing return saturates
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= LP_FULL;
      end else if (w_inc && !w_dec && (r_cnt != LP_FULL)) begin
        r_cnt <= r_cnt + LP_ONE;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - LP_ONE;
      end
    end
  end

  assign w_lcrd_legal = (int'(rx_lcrd_id_i) < VC_NUM) &&
                        ((w_credit[rx_lcrd_id_i] != LP_FULL) ||
                         (w_send && (w_head_vc == rx_lcrd_id_i)));

  // Flag credit returns that would overflow a counter or name a nonexistent VC
  always_ff @(posedge clk) begin
    if (!rst && rx_lcrd_vld_i) begin
      assert (w_lcrd_legal);
    end
  end

  // Output register: flit, VC and look-ahead route launch together one cycle after the pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_vld   <= 1'b0;
      r_tx_flit  <= '0;
      r_tx_vc    <= '0;
      r_tx_route <= N;
      r_drop     <= 1'b0;
    end else begin
      r_tx_vld <= w_send;
      r_drop   <= w_drop;
      if (w_send) begin
        r_tx_flit  <= w_head;
        r_tx_vc    <= w_head_vc;
        r_tx_route <= w_hop.port;
      end
    end
  end

  assign tx_flit_vld_o           = r_tx_vld;
  assign tx_flit_o               = r_tx_flit;
  assign tx_vc_id_o              = r_tx_vc;
  assign tx_look_ahead_routing_o = r_tx_route;
  assign drop_err_o              = r_drop;

endmodule

// File: tb/tb_rvh_noc_local_inject.sv
// tb/tb_rvh_noc_local_inject.sv - randomized and directed bench for rvh_noc_local_inject
module tb_rvh_noc_local_inject;
  import rvh_noc_pkg::*;

  localparam int VCN = 4;
  localparam int VCD = VC_DEPTH_MAX;
  localparam int FD  = LOCAL_INJECT_FIFO_DEPTH;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  node_id_t                   node_id;
  logic                       pld_vld;
  flit_payload_t              pld;
  logic                       pld_rdy;
  logic                       tx_vld;
  flit_payload_t              tx_flit;
  logic [VC_ID_NUM_MAX_W-1:0] tx_vc;
  io_port_t                   tx_route;
  logic                       lcrd_vld;
  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id;
  logic                       drop_err;

  always #5 clk = ~clk;

  rvh_noc_local_inject dut (
    .clk                     (clk),
    .rst                     (rst),
    .node_id_i               (node_id),
    .pld_vld_i               (pld_vld),
    .pld_i                   (pld),
    .pld_rdy_o               (pld_rdy),
    .tx_flit_vld_o           (tx_vld),
    .tx_flit_o               (tx_flit),
    .tx_vc_id_o              (tx_vc),
    .tx_look_ahead_routing_o (tx_route),
    .rx_lcrd_vld_i           (lcrd_vld),
    .rx_lcrd_id_i            (lcrd_id),
    .drop_err_o              (drop_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: pending payloads, credits per VC, what the outputs must show next
  flit_payload_t m_q[$];
  int            m_cred [VCN];
  logic          m_vld;
  flit_payload_t m_flit;
  int            m_port;
  logic          m_drop;
  logic          acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // first hop by X-then-Y rule; -1 means the target is this node
  function automatic int ref_port(input node_id_t cur, input node_id_t tgt);
    if (tgt.x_position > cur.x_position) return 2;
    if (tgt.x_position < cur.x_position) return 3;
    if (tgt.y_position > cur.y_position) return 0;
    if (tgt.y_position < cur.y_position) return 1;
    return -1;
  endfunction

  function automatic flit_payload_t mk(input int x, input int y);
    flit_payload_t p;
    p.data            = $urandom;
    p.qos_value       = 4'($urandom);
    p.src_id          = node_id;
    p.tgt_id.x_position = 2'(x);
    p.tgt_id.y_position = 2'(y);
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int v = 0; v < VCN; v++) m_cred[v] = VCD;
    m_vld  = 1'b0;
    m_flit = '0;
    m_port = 0;
    m_drop = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},   64'(tx_vld),   64'd0);
    check({tag, "_flit"},  64'(tx_flit),  64'd0);
    check({tag, "_vc"},    64'(tx_vc),    64'd0);
    check({tag, "_route"}, 64'(tx_route), 64'd0);
    check({tag, "_drop"},  64'(drop_err), 64'd0);
    check({tag, "_rdy"},   64'(pld_rdy),  64'd1);
  endtask

  // One clock: check outputs, drive inputs (illegal credit returns suppressed), advance the model
  task automatic step(input logic vld, input flit_payload_t p, input logic cvld_in,
                      input int cid, output logic accepted);
    logic cvld;
    logic send;
    logic drop;
    int   port;
    int   after;
    @(negedge clk);
    check("rdy",  64'(pld_rdy),  64'(m_q.size() < FD));
    check("vld",  64'(tx_vld),   64'(m_vld));
    check("drop", 64'(drop_err), 64'(m_drop));
    if (m_vld) begin
      check("flit",  64'(tx_flit),  64'(m_flit));
      check("vc",    64'(tx_vc),    64'(m_port));
      check("route", 64'(tx_route), 64'(m_port));
    end
    send = 1'b0;
    drop = 1'b0;
    port = 0;
    if (m_q.size() > 0) begin
      port = ref_port(node_id, m_q[0].tgt_id);
      if (port < 0) drop = 1'b1;
      else if (m_cred[port] > 0) send = 1'b1;
    end
    cvld = cvld_in;
    if (cvld) begin
      after = m_cred[cid] - ((send && port == cid) ? 1 : 0);
      if (after >= VCD) cvld = 1'b0;
    end
    pld_vld  = vld;
    pld      = p;
    lcrd_vld = cvld;
    lcrd_id  = 2'(cid);
    accepted = vld && (m_q.size() < FD);
    m_vld  = send;
    m_drop = drop;
    if (send) begin
      m_flit = m_q[0];
      m_port = port;
      m_cred[port]--;
    end
    if (send || drop) void'(m_q.pop_front());
    if (cvld) m_cred[cid]++;
    if (accepted) m_q.push_back(p);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 0, acc);
  endtask

  initial begin
    flit_payload_t hold;
    node_id.x_position = 2'd1;
    node_id.y_position = 2'd1;
    pld_vld  = 1'b0;
    pld      = '0;
    lcrd_vld = 1'b0;
    lcrd_id  = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    model_reset();

    // single east-bound payload
    step(1'b1, mk(3, 1), 1'b0, 0, acc);
    idle(3);

    // credit exhaustion on S, then one credit return releases the third
    for (int k = 0; k < 3; k++) step(1'b1, mk(1, 0), 1'b0, 0, acc);
    idle(4);
    step(1'b0, '0, 1'b1, 1, acc);
    idle(3);

    // drain W credits, fill the FIFO behind a blocked head, then release in order
    for (int k = 0; k < 6; k++) step(1'b1, mk(0, 1), 1'b0, 0, acc);
    hold = mk(0, 2);
    acc  = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, hold, 1'b0, 0, acc);
    for (int k = 0; k < 4; k++) begin
      if (acc) step(1'b0, '0, 1'b1, 3, acc);
      else     step(1'b1, hold, 1'b1, 3, acc);
    end
    idle(6);

    // self-targeted payload between two north-bound ones
    step(1'b1, mk(1, 2), 1'b0, 0, acc);
    step(1'b1, mk(1, 1), 1'b0, 0, acc);
    step(1'b1, mk(1, 2), 1'b0, 0, acc);
    idle(4);

    // send and return on the same VC, then on different VCs
    step(1'b1, mk(1, 2), 1'b1, 0, acc);
    step(1'b0, '0, 1'b1, 0, acc);
    step(1'b1, mk(1, 3), 1'b0, 0, acc);
    step(1'b0, '0, 1'b1, 2, acc);
    idle(3);

    // randomized traffic and credit returns
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 9) < 7), mk($urandom_range(0, 3), $urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3), acc);
    end
    idle(12);
    for (int v = 0; v < VCN; v++) begin
      while (m_cred[v] < VCD) step(1'b0, '0, 1'b1, v, acc);
    end
    idle(2);

    // reset while the FIFO holds three and a flit is on the wire
    for (int k = 0; k < 5; k++) step(1'b1, mk(3, 0), 1'b0, 0, acc);
    step(1'b1, mk(3, 0), 1'b1, 2, acc);
    step(1'b0, '0, 1'b0, 0, acc);
    @(posedge clk);
    #2;
    check("pre_rst_vld", 64'(tx_vld), 64'(m_vld));
    check("pre_rst_depth", 64'(m_q.size()), 64'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step(1'b1, mk(3, 2), 1'b0, 0, acc);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
